alu_acc: RTL and testbench
==========================

# alu_acc

Registered accumulate stage placed directly downstream of the 4-bit add/sub datapath. Each accepted operation adds or subtracts an operand to an internal accumulator, with carry, zero and overflow computed exactly as the add/sub unit does. The new value is written back as the next A operand and presented on a valid/ready output register. The block also keeps a sticky overflow flag and an operation counter for the ALU experiment top level.

## Interface
Parameters:
- WIDTH, 4, datapath width of accumulator, operand and result.
- CNT_W, 8, width of the saturating operation counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request is valid.
- in_ready  out  1  block can accept the request this cycle.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  1 = subtract (acc − B), 0 = add.
- in_clr  in  1  1 = load in_b into the accumulator instead of adding; in_sub is ignored.
- out_valid  out  1  output register holds an unconsumed result.
- out_ready  in  1  downstream consumes the result this cycle.
- out_result  out  WIDTH  registered result.
- out_carry  out  1  registered carry-out.
- out_zero  out  1  registered zero flag.
- out_overflow  out  1  registered signed overflow.
- sticky_ovf  out  1  OR of all overflows since the last reset or clear.
- op_count  out  CNT_W  number of accepted operations, saturating.

## Operation
- Handshake rules:
  - in_ready = !out_valid || out_ready (combinational).
  - An operation is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
- Add/sub arithmetic, with A = acc:
  - Bext = B XOR {WIDTH{sub}}.
  - {carry, result} = A + Bext + sub, computed at WIDTH+1 bits.
  - zero = (result == 0).
  - overflow = (A[MSB] == Bext[MSB]) && (result[MSB] != A[MSB]).
- On an accepted operation with in_clr = 0:
  - acc <= result.
  - The output register loads {result, carry, zero, overflow}.
  - sticky_ovf <= sticky_ovf | overflow.
  - op_count <= op_count + 1, saturating at all-ones.
- On an accepted operation with in_clr = 1:
  - acc <= in_b.
  - The output register loads result = in_b, carry = 0, overflow = 0, zero = (in_b == 0).
  - sticky_ovf <= 0.
  - op_count <= 1.
- Output state machine:
  - Two states: EMPTY (out_valid = 0) and FULL (out_valid = 1).
  - EMPTY → FULL on accept.
  - FULL → EMPTY on consume without accept.
  - FULL stays FULL on consume with a simultaneous accept; the register is overwritten with the new result.
  - FULL with no consume: in_ready = 0, and acc, the output register, sticky_ovf and op_count all hold.
- The output register changes only on accept.
- Reset values: acc = 0, out_valid = 0, out_result = 0, out_carry = 0, out_zero = 0, out_overflow = 0, sticky_ovf = 0, op_count = 0.
- Reset mid-operation: any pending result is discarded and no consume is reported. in_ready is 1 in the first cycle after reset is released.

## Timing
- Latency: 1 cycle. An operation accepted at edge N appears on the output with out_valid = 1 after edge N.
- Throughput: 1 operation per cycle while out_ready = 1. Back-to-back operations chain through acc with no bubble.
- The only combinational input-to-output path is out_ready → in_ready. All other outputs come straight from flops.
- Upstream must hold in_valid and its data stable until accepted. The block does not require this of itself, but the bench checks it.

## Structure
- Shared package alu_pkg holds:
  - default WIDTH and CNT_W;
  - the result/flag struct {result, carry, zero, overflow};
  - the EMPTY/FULL state encoding.
- One sub-module is natural: acc_addsub, a purely combinational WIDTH-parameterised add/sub with the flag equations above, instantiated once.
- The top level holds acc, the output register, the state machine, sticky_ovf and op_count.

## Test plan
- Reset, then clr with in_b = 4'h3, then add 4'h5 → result 4'h8, carry 0, zero 0, overflow 1; sticky_ovf = 1, op_count = 2.
- From acc = 4'h8, subtract 4'h8 → result 4'h0, carry 1, zero 1, overflow 0; sticky_ovf stays 1.
- Hold out_ready = 0 and present two requests (add 1, add 2) from acc = 0 → first accepted, out_result = 1 and in_ready = 0 held for 5 cycles with acc unchanged. After out_ready rises, the second request is accepted in the same cycle as the consume and out_result = 3 on the next cycle.
- Stream add 1 for 3 back-to-back cycles with out_ready = 1 from acc = 0 → out_result 1, 2, 3 on consecutive cycles and out_valid never drops.
- Accept 300 adds with CNT_W = 8 → op_count saturates at 255. A following clr sets op_count to 1 and sticky_ovf to 0.
- Assert rst while FULL with out_ready = 0 → next cycle out_valid = 0, acc = 0, every output at its reset value, in_ready = 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and defaults for the accumulate stage behind the 4-bit add/sub datapath.
package alu_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned CNT_W_DEF = 8;

    // Flags travel with the result; the result itself stays WIDTH-parameterised at each use.
    typedef struct packed {
        logic carry;
        logic zero;
        logic overflow;
    } flags_t;

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } out_state_e;

endpackage

// File: rtl/acc_addsub.sv
// Combinational add/sub with carry, zero and signed-overflow flags.
module acc_addsub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_result,
    output flags_t           o_flags
);

    logic [WIDTH-1:0] w_bext;
    logic [WIDTH:0]   w_sum;

    always_comb begin
        w_bext   = i_b ^ {WIDTH{i_sub}};
        w_sum    = {1'b0, i_a} + {1'b0, w_bext} + {{WIDTH{1'b0}}, i_sub};
        o_result = w_sum[WIDTH-1:0];
        o_flags.carry    = w_sum[WIDTH];
        o_flags.zero     = (w_sum[WIDTH-1:0] == '0);
        o_flags.overflow = (i_a[WIDTH-1] == w_bext[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != i_a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_acc.sv
// Registered accumulate stage with valid/ready output, sticky overflow and op counter.
module alu_acc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] op_count
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    flags_t           r_flags;
    logic             r_sticky;
    logic [CNT_W-1:0] r_op_count;
    out_state_e       r_state;
    out_state_e       w_state_next;

    logic             w_accept;
    logic             w_consume;
    logic [WIDTH-1:0] w_add_result;
    flags_t           w_add_flags;
    logic [WIDTH-1:0] w_ld_result;
    flags_t           w_ld_flags;
    logic [CNT_W-1:0] w_count_inc;

    acc_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_a      (r_acc),
        .i_b      (in_b),
        .i_sub    (in_sub),
        .o_result (w_add_result),
        .o_flags  (w_add_flags)
    );

    always_comb begin
        out_valid = (r_state == StFull);
        in_ready  = !out_valid || out_ready;
        w_accept  = in_valid && in_ready;
        w_consume = out_valid && out_ready;
    end

    // A clear loads the operand directly; carry and overflow are forced low.
    always_comb begin
        w_ld_result = w_add_result;
        w_ld_flags  = w_add_flags;
        if (in_clr) begin
            w_ld_result         = in_b;
            w_ld_flags.carry    = 1'b0;
            w_ld_flags.zero     = (in_b == '0);
            w_ld_flags.overflow = 1'b0;
        end
        w_count_inc = (&r_op_count) ? r_op_count : r_op_count + CNT_W'(1);
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StEmpty: if (w_accept) w_state_next = StFull;
            StFull:  if (w_consume && !w_accept) w_state_next = StEmpty;
            default: w_state_next = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StEmpty;
            r_acc      <= '0;
            r_result   <= '0;
            r_flags    <= '0;
            r_sticky   <= 1'b0;
            r_op_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_acc    <= w_ld_result;
                r_result <= w_ld_result;
                r_flags  <= w_ld_flags;
                if (in_clr) begin
                    r_sticky   <= 1'b0;
                    r_op_count <= CNT_W'(1);
                end else begin
                    r_sticky   <= r_sticky | w_add_flags.overflow;
                    r_op_count <= w_count_inc;
                end
            end
        end
    end

    always_comb begin
        out_result   = r_result;
        out_carry    = r_flags.carry;
        out_zero     = r_flags.zero;
        out_overflow = r_flags.overflow;
        sticky_ovf   = r_sticky;
        op_count     = r_op_count;
    end

endmodule

// File: tb/tb_alu_acc.sv
// Self-checking bench for alu_acc: hand vectors, handshake corner cases, random model check.
module tb_alu_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_b;
    logic       in_sub;
    logic       in_clr;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_carry;
    logic       out_zero;
    logic       out_overflow;
    logic       sticky_ovf;
    logic [7:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_acc, m_res, m_cnt;
    bit m_full, m_c, m_z, m_o, m_sticky;

    always #5 clk = ~clk;

    alu_acc #(
        .WIDTH (4),
        .CNT_W (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_b         (in_b),
        .in_sub       (in_sub),
        .in_clr       (in_clr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .sticky_ovf   (sticky_ovf),
        .op_count     (op_count)
    );

    typedef struct {
        logic [3:0] b;
        logic       sub;
        logic       clr;
        logic [3:0] result;
        logic       carry;
        logic       zero;
        logic       ovf;
        logic       sticky;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] b, input logic s, input logic c,
                         input logic r);
        in_valid  = v;
        in_b      = b;
        in_sub    = s;
        in_clr    = c;
        out_ready = r;
    endtask

    task automatic model_reset();
        m_acc = 0; m_res = 0; m_cnt = 0;
        m_full = 0; m_c = 0; m_z = 0; m_o = 0; m_sticky = 0;
    endtask

    // Arithmetic on integers: signed range check gives overflow, unsigned range gives carry.
    task automatic model_op(input int b, input bit sub, input bit clr);
        int sa, sb, ss, s;
        if (clr) begin
            m_res = b; m_c = 0; m_o = 0; m_sticky = 0; m_cnt = 1;
        end else begin
            sa = (m_acc > 7) ? m_acc - 16 : m_acc;
            sb = (b > 7) ? b - 16 : b;
            if (sub) begin
                s = m_acc - b + 16; m_c = (m_acc >= b); ss = sa - sb;
            end else begin
                s = m_acc + b; m_c = (s > 15); ss = sa + sb;
            end
            m_res    = s % 16;
            m_o      = (ss > 7) || (ss < -8);
            m_sticky = m_sticky | m_o;
            m_cnt    = (m_cnt == 255) ? 255 : m_cnt + 1;
        end
        m_z   = (m_res == 0);
        m_acc = m_res;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, out_valid, m_full);
        check({tag, ".result"}, out_result, m_res);
        check({tag, ".carry"}, out_carry, m_c);
        check({tag, ".zero"}, out_zero, m_z);
        check({tag, ".ovf"}, out_overflow, m_o);
        check({tag, ".sticky"}, sticky_ovf, m_sticky);
        check({tag, ".cnt"}, op_count, m_cnt);
    endtask

    // Called at a negedge: drives one cycle, checks in_ready, advances the model, checks outputs.
    task automatic model_cycle(input string tag, input logic v, input logic [3:0] b,
                               input logic s, input logic c, input logic r);
        bit exp_ready;
        drive(v, b, s, c, r);
        exp_ready = !m_full || r;
        #1;
        check({tag, ".in_ready"}, in_ready, exp_ready);
        if (v && exp_ready) begin
            model_op(b, s, c);
            m_full = 1;
        end else if (m_full && r) begin
            m_full = 0;
        end
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".valid"}, out_valid, 0);
        check({tag, ".result"}, out_result, 0);
        check({tag, ".carry"}, out_carry, 0);
        check({tag, ".zero"}, out_zero, 0);
        check({tag, ".ovf"}, out_overflow, 0);
        check({tag, ".sticky"}, sticky_ovf, 0);
        check({tag, ".cnt"}, op_count, 0);
        check({tag, ".in_ready"}, in_ready, 1);
    endtask

    initial begin
        vecs[0] = '{4'h3, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[1] = '{4'h5, 1'b0, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2};
        vecs[2] = '{4'h8, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3};
        vecs[3] = '{4'h1, 1'b1, 1'b0, 4'hf, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4};
        vecs[4] = '{4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd5};
        vecs[5] = '{4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[6] = '{4'h7, 1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
        vecs[7] = '{4'h9, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};

        rst = 1'b1;
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");
        model_reset();

        // Back-to-back hand vectors with out_ready held high
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].b, vecs[i].sub, vecs[i].clr, 1'b1);
            @(negedge clk);
            check($sformatf("vec%0d.result", i), out_result, vecs[i].result);
            check($sformatf("vec%0d.carry", i), out_carry, vecs[i].carry);
            check($sformatf("vec%0d.zero", i), out_zero, vecs[i].zero);
            check($sformatf("vec%0d.ovf", i), out_overflow, vecs[i].ovf);
            check($sformatf("vec%0d.sticky", i), sticky_ovf, vecs[i].sticky);
            check($sformatf("vec%0d.cnt", i), op_count, vecs[i].cnt);
            check($sformatf("vec%0d.valid", i), out_valid, 1);
        end

        // Backpressure: clear to 0, drain, then two adds with out_ready low
        drive(1'b1, 4'h0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("bp.drained", out_valid, 0);
        drive(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp.in_ready", in_ready, 0);
            check("bp.result", out_result, 1);
            check("bp.valid", out_valid, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp.ready_comb", in_ready, 1);
        @(negedge clk);
        check("bp.second", out_result, 3);
        check("bp.second_valid", out_valid, 1);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("bp.empty", out_valid, 0);

        // Streaming: clear then three back-to-back add 1
        drive(1'b1, 4'h0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 4'h1, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            check("stream.result", out_result, i);
            check("stream.valid", out_valid, 1);
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        // Random traffic against the model
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            model_cycle("rand", 1'($urandom_range(0, 3) != 0), 4'($urandom),
                        1'($urandom), 1'($urandom_range(0, 15) == 0),
                        1'($urandom_range(0, 2) != 0));
        end

        // Saturation: 300 adds after a clear, then a clear resets count and sticky
        model_cycle("sat.clr", 1'b1, 4'h0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            model_cycle("sat", 1'b1, 4'($urandom), 1'($urandom), 1'b0, 1'b1);
        end
        check("sat.cnt255", op_count, 255);
        model_cycle("sat.clr2", 1'b1, 4'h4, 1'b0, 1'b1, 1'b1);
        check("sat.cnt1", op_count, 1);
        check("sat.sticky0", sticky_ovf, 0);

        // Reset while FULL with out_ready low
        drive(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("rstfull.full", out_valid, 1);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("rstfull");
        // Accumulator must be zero: adding 0 yields 0 with zero flag
        drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("rstfull.acc", out_result, 0);
        check("rstfull.acc_zero", out_zero, 1);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
